// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    SEND_DATA = 3'd2,
    WAIT      = 3'd3,
    GUARD     = 3'd4
  } state_t;

  // 16 ticks per bit x (start + 8 data + stop)
  localparam int TICKS_PER_FRAME = 160;
  localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          found
);

  // Scan offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        winner = IW'((int'(ptr) + k) % N);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin multi-client front end for the 16x UART transmitter; paces bytes by counting tick_in.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  bit HEADER_EN = 1'b0,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [15:0]          frames_sent,
  output state_t               state_dbg
);

  localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_FRAME - 1);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     tick_cnt;
  logic           last_q;
  logic [IDW-1:0] arb_winner;
  logic           arb_found;
  logic           gnt_valid;
  logic           gnt_last;
  logic [7:0]     gnt_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .found  (arb_found)
  );

  assign gnt_valid = req_valid[grant_id];
  assign gnt_last  = req_last[grant_id];
  assign gnt_data  = req_data[8*grant_id +: 8];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Handshake: requester i hands over a byte in the cycle where req_valid[i] && req_ready[i].
  // req_ready is offered only to the granted requester in SEND_DATA, and tx_start fires in
  // exactly that accepting cycle; a header byte pulses tx_start with no req_ready.
  always_comb begin
    tx_start  = 1'b0;
    tx_byte   = 8'h00;
    req_ready = '0;
    case (state)
      SEND_HDR: begin
        tx_start = 1'b1;
        tx_byte  = {HDR_TAG, 4'(grant_id)};
      end
      SEND_DATA: begin
        req_ready[grant_id] = 1'b1;
        if (gnt_valid) begin
          tx_start = 1'b1;
          tx_byte  = gnt_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      tick_cnt    <= '0;
      last_q      <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_winner;
            state    <= HEADER_EN ? SEND_HDR : SEND_DATA;
          end
        end
        SEND_HDR: begin
          last_q   <= 1'b0;
          tick_cnt <= '0;
          state    <= WAIT;
        end
        SEND_DATA: begin
          if (gnt_valid) begin
            last_q   <= gnt_last;
            tick_cnt <= '0;
            state    <= WAIT;
          end
        end
        // A tick in the send cycle is ignored: the transmitter only leaves IDLE after it.
        WAIT: begin
          if (tick_in) begin
            if (tick_cnt == LAST_TICK) state <= GUARD;
            else tick_cnt <= tick_cnt + 8'd1;
          end
        end
        GUARD: begin
          if (last_q) begin
            frames_sent <= frames_sent + 16'd1;
            rr_ptr      <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state       <= IDLE;
          end else begin
            state <= SEND_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: grant table, scoreboard of bytes/grants, multi-cycle corner cases.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [IDW-1:0]  gnt;
  } vec_t;

  // clock / reset
  logic system_clk = 1'b0;
  logic rst        = 1'b1;
  logic tick_in    = 1'b0;
  always #5 system_clk = ~system_clk;

  // main DUT (no header)
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [8*NREQ-1:0] req_data;
  logic              tx_start, busy;
  logic [7:0]        tx_byte;
  logic [IDW-1:0]    grant_id;
  logic [15:0]       frames_sent;
  uart_pkg::state_t  state_dbg;

  // header DUT
  logic [NREQ-1:0]   hdr_valid, hdr_last, hdr_ready;
  logic [8*NREQ-1:0] hdr_data;
  logic              hdr_tx_start, hdr_busy;
  logic [7:0]        hdr_tx_byte;
  logic [IDW-1:0]    hdr_grant_id;
  logic [15:0]       hdr_frames_sent;
  uart_pkg::state_t  hdr_state_dbg;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .HEADER_EN(1'b0)) u_dut (
    .system_clk (system_clk), .rst (rst), .tick_in (tick_in),
    .req_valid (req_valid), .req_data (req_data), .req_last (req_last), .req_ready (req_ready),
    .tx_start (tx_start), .tx_byte (tx_byte), .busy (busy), .grant_id (grant_id),
    .frames_sent (frames_sent), .state_dbg (state_dbg)
  );

  uart_tx_scheduler #(.NUM_REQ(NREQ), .HEADER_EN(1'b1)) u_hdr (
    .system_clk (system_clk), .rst (rst), .tick_in (tick_in),
    .req_valid (hdr_valid), .req_data (hdr_data), .req_last (hdr_last), .req_ready (hdr_ready),
    .tx_start (hdr_tx_start), .tx_byte (hdr_tx_byte), .busy (hdr_busy), .grant_id (hdr_grant_id),
    .frames_sent (hdr_frames_sent), .state_dbg (hdr_state_dbg)
  );

  // requester sources: {last, data} per byte
  logic [8:0]      src_mem [NREQ][8];
  int              src_len [NREQ];
  int              src_idx [NREQ];
  logic [NREQ-1:0] src_en;

  // scoreboard and monitor state
  logic [7:0]     exp_q[$];
  logic [IDW-1:0] exp_gnt_q[$];
  logic [7:0]     hdr_got_q[$];
  int             hdr_t_q[$];
  int             hdr_tk_q[$];
  int             hdr_co_q[$];
  int total = 0, bad = 0;
  int cyc = 0, tick_div = 0, tick_total = 0;
  int start_cnt = 0, busy_cnt = 0, rdy0_cnt = 0, gnt_nz_cnt = 0;
  logic prev_start = 1'b0, last_busy = 1'b0, hdr_last_busy = 1'b0;
  logic [NREQ-1:0] hs, hdr_hs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic clear_src();
    src_en = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input logic last);
    src_mem[i][src_len[i]] = {last, d};
    src_len[i]++;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [IDW-1:0] g);
    exp_q.push_back(d);
    exp_gnt_q.push_back(g);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_en[i] && src_idx[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_idx[i]][7:0];
        req_last[i]        = src_mem[i][src_idx[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: drive at posedge+1, observe at negedge, advance sources after the edge.
  task automatic cycle();
    drive_inputs();
    tick_in = (tick_div == 0);
    @(negedge system_clk);
    hs     = req_valid & req_ready;
    hdr_hs = hdr_valid & hdr_ready;
    if (busy) busy_cnt++;
    if (req_ready[0]) rdy0_cnt++;
    if (grant_id != '0) gnt_nz_cnt++;
    if (tx_start) begin
      start_cnt++;
      check("no_back_to_back_start", 32'(prev_start), 0);
      check("ready_with_start", 32'(req_ready), 32'(1) << grant_id);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got byte=%0h grant=%0d, expected no start", tx_byte, grant_id);
      end else begin
        check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
        check("grant_at_start", 32'(grant_id), 32'(exp_gnt_q.pop_front()));
      end
    end
    prev_start = tx_start;
    last_busy  = busy;
    if (hdr_tx_start) begin
      hdr_got_q.push_back(hdr_tx_byte);
      hdr_t_q.push_back(cyc);
      hdr_tk_q.push_back(tick_total);
      hdr_co_q.push_back(int'(tick_in));
    end
    hdr_last_busy = hdr_busy;
    if (tick_in) tick_total++;
    @(posedge system_clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) src_idx[i]++;
    hdr_valid = hdr_valid & ~hdr_hs;
    tick_div  = (tick_div == 3) ? 0 : tick_div + 1;
    cyc++;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((exp_q.size() != 0 || last_busy) && n < budget);
    if (exp_q.size() != 0 || last_busy) begin
      fail_timeout(name);
      exp_q.delete();
      exp_gnt_q.delete();
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   s0;
    int   n;
    vecs[0] = '{mask: 4'b0110, gnt: 2'd1};
    vecs[1] = '{mask: 4'b1000, gnt: 2'd3};
    vecs[2] = '{mask: 4'b1111, gnt: 2'd0};
    vecs[3] = '{mask: 4'b1100, gnt: 2'd2};
    vecs[4] = '{mask: 4'b0101, gnt: 2'd0};
    vecs[5] = '{mask: 4'b1010, gnt: 2'd1};

    req_valid = '0; req_last = '0; req_data = '0;
    hdr_valid = '0; hdr_last = '0; hdr_data = '0;
    clear_src();
    rst = 1'b1;
    repeat (2) cycle();

    // reset state
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_frames", 32'(frames_sent), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_hdr_busy", 32'(hdr_busy), 0);
    rst = 1'b0;

    // grant table from the post-reset pointer: start pulse exactly one cycle after request
    foreach (vecs[v]) begin
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      clear_src();
      for (int i = 0; i < NREQ; i++) if (vecs[v].mask[i]) add_byte(i, 8'hC0 | 8'(i), 1'b1);
      src_en = vecs[v].mask;
      expect_byte(8'hC0 | 8'(vecs[v].gnt), vecs[v].gnt);
      s0 = start_cnt;
      cycle();
      cycle();
      check($sformatf("vec%0d_start_latency", v), 32'(start_cnt - s0), 1);
      exp_q.delete();
      exp_gnt_q.delete();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_src();

    // single byte, tick coincident with tx_start
    add_byte(0, 8'h55, 1'b1);
    expect_byte(8'h55, 2'd0);
    busy_cnt = 0; rdy0_cnt = 0; s0 = start_cnt;
    tick_div = 3;
    src_en = 4'b0001;
    wait_done(3000, "single_done");
    check("single_starts", 32'(start_cnt - s0), 1);
    check("single_ready_cycles", 32'(rdy0_cnt), 1);
    check("single_busy_cycles", 32'(busy_cnt), 642);
    check("single_frames", 32'(frames_sent), 1);

    // round robin: 1 and 2 from the start, 3 joins later
    clear_src();
    add_byte(1, 8'h10, 1'b1); add_byte(1, 8'h11, 1'b1);
    add_byte(2, 8'h20, 1'b1); add_byte(2, 8'h21, 1'b1);
    add_byte(3, 8'h30, 1'b1); add_byte(3, 8'h31, 1'b1);
    expect_byte(8'h10, 2'd1); expect_byte(8'h20, 2'd2); expect_byte(8'h30, 2'd3);
    expect_byte(8'h11, 2'd1); expect_byte(8'h21, 2'd2); expect_byte(8'h31, 2'd3);
    src_en = 4'b0110;
    repeat (100) cycle();
    src_en = 4'b1110;
    wait_done(6000, "rr_done");
    check("rr_frames", 32'(frames_sent), 7);

    // packet lock: requester 1 waits for the whole packet of requester 0
    clear_src();
    add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b0); add_byte(0, 8'h33, 1'b1);
    add_byte(1, 8'h99, 1'b1);
    expect_byte(8'h11, 2'd0); expect_byte(8'h22, 2'd0); expect_byte(8'h33, 2'd0);
    expect_byte(8'h99, 2'd1);
    src_en = 4'b0011;
    wait_done(5000, "lock_done");
    check("lock_frames", 32'(frames_sent), 9);

    // stall mid-packet with another requester pending
    clear_src();
    add_byte(0, 8'h40, 1'b0); add_byte(0, 8'h41, 1'b1);
    add_byte(2, 8'h42, 1'b1);
    expect_byte(8'h40, 2'd0); expect_byte(8'h41, 2'd0); expect_byte(8'h42, 2'd2);
    src_en = 4'b0001;
    n = 0;
    while (src_idx[0] != 1 && n < 10) begin
      cycle();
      n++;
    end
    if (src_idx[0] != 1) fail_timeout("stall_first_byte");
    src_en = 4'b0100;
    s0 = start_cnt;
    gnt_nz_cnt = 0;
    repeat (642 + 500) cycle();
    check("stall_no_start", 32'(start_cnt - s0), 0);
    check("stall_grant_kept", 32'(gnt_nz_cnt), 0);
    check("stall_busy", 32'(last_busy), 1);
    src_en = 4'b0101;
    wait_done(3000, "stall_done");
    check("stall_frames", 32'(frames_sent), 11);

    // move pointer to 1, then reset during WAIT of another packet
    clear_src();
    add_byte(0, 8'h66, 1'b1);
    expect_byte(8'h66, 2'd0);
    src_en = 4'b0001;
    wait_done(2000, "pre_rst_done");
    check("pre_rst_frames", 32'(frames_sent), 12);
    clear_src();
    add_byte(2, 8'h77, 1'b1);
    expect_byte(8'h77, 2'd2);
    src_en = 4'b0100;
    repeat (100) cycle();
    check("pre_rst_byte_sent", 32'(exp_q.size()), 0);
    check("pre_rst_busy", 32'(last_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_tx_byte", 32'(tx_byte), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    check("mid_rst_frames", 32'(frames_sent), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    clear_src();
    exp_q.delete();
    exp_gnt_q.delete();
    cycle();
    rst = 1'b0;
    add_byte(0, 8'h01, 1'b1);
    add_byte(1, 8'h02, 1'b1);
    expect_byte(8'h01, 2'd0); expect_byte(8'h02, 2'd1);
    src_en = 4'b0011;
    wait_done(3000, "post_rst_done");
    check("post_rst_frames", 32'(frames_sent), 2);

    // header instance: requester 3, tick coincident with the header pulse
    clear_src();
    hdr_data = '0;
    hdr_data[31:24] = 8'h7E;
    hdr_last = 4'b1000;
    hdr_valid = 4'b1000;
    tick_div = 3;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((hdr_got_q.size() < 2 || hdr_last_busy) && n < 2000);
    if (hdr_got_q.size() < 2 || hdr_last_busy) fail_timeout("hdr_done");
    check("hdr_pulse_count", 32'(hdr_got_q.size()), 2);
    if (hdr_got_q.size() >= 2) begin
      check("hdr_first_byte", 32'(hdr_got_q[0]), 32'h A3);
      check("hdr_second_byte", 32'(hdr_got_q[1]), 32'h7E);
      check("hdr_pulse_spacing", 32'(hdr_t_q[1] - hdr_t_q[0]), 642);
      check("hdr_tick_on_pulse", 32'(hdr_co_q[0]), 1);
      check("hdr_ticks_between", 32'(hdr_tk_q[1] - hdr_tk_q[0] - hdr_co_q[0]), 160);
    end
    check("hdr_frames", 32'(hdr_frames_sent), 1);
    check("hdr_grant_id", 32'(hdr_grant_id), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
